// File: rtl/spi_pkg.sv
// Shared constants, FSM state encoding and frame-width helper for the SPI register-file peripheral.
package spi_pkg;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  function automatic int frame_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pad input, with single-clk rise/fall pulses.
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral giving an external controller read/write access to a
// NUM_REGS x DATA_W register file in the clk domain.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   err_count
);
  localparam int FW = frame_w(ADDR_W, DATA_W);
  localparam int CW = $clog2(FW + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .d_i(ncs), .q_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .d_i(copi), .q_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, ncs_lvl, copi_rise, copi_fall};

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q;
  logic [FW-2:0]                   rx_q;
  logic [DATA_W-1:0]               tx_q;
  logic                            oe_q, wr_strobe_q;
  logic [ADDR_W-1:0]               wr_addr_q;
  logic [7:0]                      err_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  logic [FW-1:0]     rx_d;
  logic              last_addr, last_data, abort, err_inc, tx_shift;
  logic [ADDR_W-1:0] addr_a, addr_w;
  logic              valid_a, valid_w, do_read, do_write;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A synced ncs rise overrides any SCLK edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (ncs_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (ncs_fall) state_d = ADDR;
        ADDR:    if (sclk_rise && cnt_q == CW'(ADDR_W)) state_d = DATA;
        DATA:    if (sclk_rise && cnt_q == CW'(FW - 1)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rx_d      = {rx_q, copi_lvl};
    last_addr = !ncs_rise && sclk_rise && state_q == ADDR && cnt_q == CW'(ADDR_W);
    last_data = !ncs_rise && sclk_rise && state_q == DATA && cnt_q == CW'(FW - 1);
    addr_a    = rx_d[ADDR_W-1:0];
    addr_w    = rx_d[DATA_W +: ADDR_W];
    valid_a   = int'(addr_a) < NUM_REGS;
    valid_w   = int'(addr_w) < NUM_REGS;
    do_read   = last_addr && rx_d[ADDR_W] == RW_READ;
    do_write  = last_data && rx_d[FW-1] == RW_WRITE && valid_w;
    abort     = ncs_rise && cnt_q != '0 && cnt_q != CW'(FW);
    err_inc   = abort || (do_read && !valid_a) ||
                (last_data && rx_d[FW-1] == RW_WRITE && !valid_w);
    // The fall right after the address phase must keep the MSB on the line.
    tx_shift  = !ncs_rise && sclk_fall && oe_q && state_q == DATA &&
                cnt_q != CW'(ADDR_W + 1);
    rd_word   = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_a == ADDR_W'(i)) rd_word = regs_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= '0;
      regs_q      <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (ncs_rise) begin
        cnt_q <= '0;
        oe_q  <= 1'b0;
      end else if (state_q == IDLE && ncs_fall) begin
        cnt_q <= '0;
      end else if ((state_q == ADDR || state_q == DATA) && sclk_rise) begin
        cnt_q <= cnt_q + CW'(1);
        rx_q  <= rx_d[FW-2:0];
      end
      if (do_read) begin
        tx_q <= valid_a ? rd_word : '0;
        oe_q <= 1'b1;
      end else if (tx_shift) begin
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end
      if (do_write) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (addr_w == ADDR_W'(i)) regs_q[i] <= rx_d[DATA_W-1:0];
        wr_strobe_q <= 1'b1;
        wr_addr_q   <= addr_w;
      end
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign cipo      = oe_q & tx_q[DATA_W-1];
  assign cipo_oe   = oe_q;
  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench: a default-parameter instance (A) and a 4/16/16 instance (B).
module tb_spi_regfile_peripheral;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sclk_a, ncs_a, copi_a, cipo_a, oe_a, strb_a;
  logic [39:0] regs_a;
  logic [6:0]  wra_a;
  logic [7:0]  err_a;
  logic         sclk_b, ncs_b, copi_b, cipo_b, oe_b, strb_b;
  logic [255:0] regs_b;
  logic [3:0]   wra_b;
  logic [7:0]   err_b;

  spi_regfile_peripheral u_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .ncs(ncs_a), .copi(copi_a),
    .cipo(cipo_a), .cipo_oe(oe_a), .regs_flat(regs_a), .wr_strobe(strb_a),
    .wr_addr(wra_a), .err_count(err_a));

  spi_regfile_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b),
    .cipo(cipo_b), .cipo_oe(oe_b), .regs_flat(regs_b), .wr_strobe(strb_b),
    .wr_addr(wra_b), .err_count(err_b));

  int checks = 0, failures = 0;
  int strb_cnt_a = 0, strb_cnt_b = 0;
  logic [15:0] sb_q[$];

  always @(negedge clk) begin
    if (strb_a) strb_cnt_a++;
    if (strb_b) strb_cnt_b++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input bit b, input logic s, input logic n, input logic d);
    if (b) begin sclk_b = s; ncs_b = n; copi_b = d; end
    else   begin sclk_a = s; ncs_a = n; copi_a = d; end
  endtask

  // Sends bits[n-1:0] MSB first; captures cipo/cipo_oe just before every SCLK rise.
  task automatic frame(input bit b, input logic [63:0] bits, input int n,
                       output logic [63:0] rd, output logic [63:0] oe);
    rd = '0; oe = '0;
    set_pins(b, 1'b0, 1'b0, 1'b0);
    wclk(8);
    for (int i = n - 1; i >= 0; i--) begin
      set_pins(b, 1'b0, 1'b0, bits[i]);
      wclk(8);
      rd = {rd[62:0], b ? cipo_b : cipo_a};
      oe = {oe[62:0], b ? oe_b : oe_a};
      set_pins(b, 1'b1, 1'b0, bits[i]);
      wclk(8);
    end
    set_pins(b, 1'b0, 1'b0, 1'b0);
    wclk(8);
    set_pins(b, 1'b0, 1'b1, 1'b0);
    wclk(8);
  endtask

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         exp_strb;
    logic [7:0] exp_err;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [63:0] rd, oe;
    logic [15:0] exp;
    int          s0, idx;

    vecs[0] = '{1'b1, 7'h02, 8'hA5, 8'h00, 1, 8'd0};
    vecs[1] = '{1'b0, 7'h02, 8'h00, 8'hA5, 0, 8'd0};
    vecs[2] = '{1'b1, 7'h7F, 8'h11, 8'h00, 0, 8'd1};
    vecs[3] = '{1'b0, 7'h00, 8'hFF, 8'h00, 0, 8'd1};
    vecs[4] = '{1'b1, 7'h04, 8'h5A, 8'h00, 1, 8'd1};
    vecs[5] = '{1'b0, 7'h04, 8'h00, 8'h5A, 0, 8'd1};
    vecs[6] = '{1'b0, 7'h7F, 8'h00, 8'h00, 0, 8'd2};
    vecs[7] = '{1'b1, 7'h00, 8'hC3, 8'h00, 1, 8'd2};

    rst = 1'b1;
    set_pins(1'b0, 1'b0, 1'b1, 1'b0);
    set_pins(1'b1, 1'b0, 1'b1, 1'b0);
    wclk(4);
    chk("reset_regs", 64'(regs_a), 64'h0);
    chk("reset_strobe", 64'(strb_a), 64'h0);
    chk("reset_wr_addr", 64'(wra_a), 64'h0);
    chk("reset_err", 64'(err_a), 64'h0);
    chk("reset_cipo", 64'(cipo_a), 64'h0);
    chk("reset_oe", 64'(oe_a), 64'h0);
    rst = 1'b0;
    wclk(4);

    for (int v = 0; v < 8; v++) begin
      s0 = strb_cnt_a;
      if (!vecs[v].wr) sb_q.push_back({8'h00, vecs[v].exp_rd});
      frame(1'b0, 64'({vecs[v].wr, vecs[v].addr, vecs[v].data}), 16, rd, oe);
      chk($sformatf("v%0d_strobes", v), 64'(strb_cnt_a - s0), 64'(vecs[v].exp_strb));
      chk($sformatf("v%0d_err", v), 64'(err_a), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_oe_mask", v), oe[15:0], vecs[v].wr ? 64'h0 : 64'h00FF);
      chk($sformatf("v%0d_oe_after", v), 64'({oe_a, cipo_a}), 64'h0);
      if (vecs[v].wr && vecs[v].exp_strb == 1) begin
        idx = int'(vecs[v].addr);
        chk($sformatf("v%0d_reg", v), 64'(regs_a[idx*8 +: 8]), 64'(vecs[v].data));
        chk($sformatf("v%0d_wr_addr", v), 64'(wra_a), 64'(vecs[v].addr));
      end
      if (!vecs[v].wr) begin
        exp = sb_q.pop_front();
        chk($sformatf("v%0d_read", v), 64'(rd[7:0]), 64'(exp[7:0]));
      end
      if (v == 0) chk("v0_other_regs", 64'(regs_a), 64'h00_00A5_0000);
    end

    // Abort a write to addr 0 after 10 of 16 bits.
    s0 = strb_cnt_a;
    frame(1'b0, 64'({1'b1, 7'h00, 8'hFF}) >> 6, 10, rd, oe);
    chk("abort_reg0", 64'(regs_a[7:0]), 64'hC3);
    chk("abort_err", 64'(err_a), 64'd3);
    chk("abort_strobes", 64'(strb_cnt_a - s0), 64'd0);
    frame(1'b0, 64'({1'b1, 7'h03, 8'h96}), 16, rd, oe);
    chk("post_abort_reg3", 64'(regs_a[31:24]), 64'h96);
    chk("post_abort_strobes", 64'(strb_cnt_a - s0), 64'd1);
    chk("post_abort_err", 64'(err_a), 64'd3);

    // Reset in the middle of a frame, then a fresh write.
    set_pins(1'b0, 1'b0, 1'b0, 1'b1);
    wclk(8);
    for (int i = 0; i < 6; i++) begin
      set_pins(1'b0, 1'b1, 1'b0, 1'b1); wclk(8);
      set_pins(1'b0, 1'b0, 1'b0, 1'b1); wclk(8);
    end
    rst = 1'b1;
    wclk(2);
    chk("midrst_regs", 64'(regs_a), 64'h0);
    chk("midrst_err", 64'(err_a), 64'h0);
    chk("midrst_misc", 64'({strb_a, wra_a, oe_a, cipo_a}), 64'h0);
    rst = 1'b0;
    set_pins(1'b0, 1'b0, 1'b1, 1'b0);
    wclk(8);
    s0 = strb_cnt_a;
    frame(1'b0, 64'({1'b1, 7'h01, 8'h3C}), 16, rd, oe);
    chk("midrst_write_regs", 64'(regs_a), 64'h00_0000_3C00);
    chk("midrst_write_strobes", 64'(strb_cnt_a - s0), 64'd1);
    chk("midrst_write_err", 64'(err_a), 64'd0);
    chk("midrst_write_addr", 64'(wra_a), 64'd1);

    // Wide instance: 21-bit frames.
    s0 = strb_cnt_b;
    frame(1'b1, 64'({1'b1, 4'hF, 16'hBEEF}), 21, rd, oe);
    chk("b_write_reg15", 64'(regs_b[255:240]), 64'hBEEF);
    chk("b_write_addr", 64'(wra_b), 64'hF);
    chk("b_write_strobes", 64'(strb_cnt_b - s0), 64'd1);
    sb_q.push_back(16'hBEEF);
    frame(1'b1, 64'({1'b0, 4'hF, 16'h0000}), 21, rd, oe);
    exp = sb_q.pop_front();
    chk("b_read_reg15", 64'(rd[15:0]), 64'(exp));
    chk("b_read_oe_mask", oe[20:0], 64'h0FFFF);
    s0 = strb_cnt_b;
    frame(1'b1, 64'({1'b1, 4'h5, 16'h1234}) << 20, 41, rd, oe);
    chk("b_extra_sclk_strobes", 64'(strb_cnt_b - s0), 64'd1);
    chk("b_extra_sclk_reg5", 64'(regs_b[95:80]), 64'h1234);
    chk("b_extra_sclk_err", 64'(err_b), 64'd0);
    chk("b_reg15_kept", 64'(regs_b[255:240]), 64'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
